// File: rtl/list_fold_sink_if.sv
// List handshake between a requesting consumer and a list producer.
// The consumer raises req; the producer answers with an ack strobe that
// qualifies eol and value for that single cycle.
interface list_fold_sink_if #(
    parameter int WIDTH = 8
) ();

    logic             req;
    logic             ack;
    logic             eol;
    logic [WIDTH-1:0] value;

    // Consumer side: issues requests, receives elements.
    modport master (
        output req,
        input  ack,
        input  eol,
        input  value
    );

    // Producer side: answers requests with elements or end-of-list.
    modport slave (
        input  req,
        output ack,
        output eol,
        output value
    );

endinterface

// File: rtl/list_fold_sink.sv
// Consumer for list-producing blocks: pulls elements until end-of-list and
// folds them into a wrapping signed sum, a saturating count and signed
// min/max. A watchdog aborts the run if the producer stops answering.
module list_fold_sink #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_WIDTH = 8,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic                 start,
    output logic                 done,
    list_fold_sink_if.master     lst,
    output logic [ACC_WIDTH-1:0] sum,
    output logic [CNT_WIDTH-1:0] count,
    output logic [WIDTH-1:0]     min_v,
    output logic [WIDTH-1:0]     max_v,
    output logic                 empty,
    output logic                 err_timeout
);

    localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WD_WIDTH-1:0] wdog;

    logic run_start;
    logic elem_take;
    logic list_end;
    logic wd_expired;

    // start only matters while no run is in flight
    assign run_start  = start && ((state == IDLE) || (state == DONE));
    assign elem_take  = (state == REQ) && lst.ack && !lst.eol;
    assign list_end   = (state == REQ) && lst.ack && lst.eol;
    // Fires on the cycle after the watchdog has already counted TIMEOUT
    // unanswered cycles, so done lands TIMEOUT+1 cycles after req rises.
    assign wd_expired = (state == REQ) && !lst.ack && (wdog == WD_WIDTH'(TIMEOUT));

    // State register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: one GAP cycle after every accepted element
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (lst.ack) begin
                    state_nxt = lst.eol ? DONE : GAP;
                end else if (wd_expired) begin
                    state_nxt = DONE;
                end
            end
            GAP: begin
                state_nxt = REQ;
            end
            DONE: begin
                if (start) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from the state register, so req drops with reset
    always_comb begin
        lst.req = (state == REQ);
        done    = (state == DONE);
    end

    // Watchdog: counts unanswered request cycles, cleared in every GAP
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wdog <= '0;
        end else if (run_start || (state == GAP)) begin
            wdog <= '0;
        end else if ((state == REQ) && !lst.ack && !wd_expired) begin
            wdog <= wdog + WD_WIDTH'(1);
        end
    end

    // Fold accumulators: sum, saturating count, signed extremes
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sum   <= '0;
            count <= '0;
            min_v <= '0;
            max_v <= '0;
        end else if (run_start) begin
            sum   <= '0;
            count <= '0;
            min_v <= MOST_POS;
            max_v <= MOST_NEG;
        end else if (elem_take) begin
            sum <= sum + ACC_WIDTH'($signed(lst.value));
            if (count != '1) begin
                count <= count + CNT_WIDTH'(1);
            end
            if ($signed(lst.value) < $signed(min_v)) begin
                min_v <= lst.value;
            end
            if ($signed(lst.value) > $signed(max_v)) begin
                max_v <= lst.value;
            end
        end else if (list_end && (count == '0)) begin
            min_v <= '0;
            max_v <= '0;
        end
    end

    // Run status flags, settled on entry to DONE
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            empty       <= 1'b0;
            err_timeout <= 1'b0;
        end else if (run_start) begin
            empty       <= 1'b0;
            err_timeout <= 1'b0;
        end else if (list_end) begin
            empty <= (count == '0);
        end else if (wd_expired) begin
            empty       <= 1'b0;
            err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_list_fold_sink.sv
// Bench for list_fold_sink: a randomized producer drives two instances
// (default widths with a long watchdog, and an 8-bit accumulator with a
// short watchdog); results are compared with a list-level reference model.
module tb_list_fold_sink;

    localparam int WIDTH      = 8;
    localparam int CNT_WIDTH  = 8;
    localparam int WD_TIMEOUT = 15;
    localparam int RUN_LIMIT  = 5000;

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b1;

    always #10 CLOCK_50 = ~CLOCK_50;

    logic             sel     = 1'b0;
    logic             start_d = 1'b0;
    logic             ack_d   = 1'b0;
    logic             eol_d   = 1'b0;
    logic [WIDTH-1:0] value_d = '0;

    list_fold_sink_if #(.WIDTH(WIDTH)) bus0 ();
    list_fold_sink_if #(.WIDTH(WIDTH)) bus1 ();

    assign bus0.ack   = ack_d & ~sel;
    assign bus0.eol   = eol_d;
    assign bus0.value = value_d;
    assign bus1.ack   = ack_d & sel;
    assign bus1.eol   = eol_d;
    assign bus1.value = value_d;

    logic start0, start1;
    assign start0 = start_d & ~sel;
    assign start1 = start_d & sel;

    logic                 done0, done1;
    logic [15:0]          sum0;
    logic [7:0]           sum1;
    logic [CNT_WIDTH-1:0] count0, count1;
    logic [WIDTH-1:0]     min0, max0, min1, max1;
    logic                 empty0, empty1, err0, err1;

    list_fold_sink #(
        .WIDTH(WIDTH), .ACC_WIDTH(16), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT(1023)
    ) dut0 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start0), .done(done0),
        .lst(bus0), .sum(sum0), .count(count0), .min_v(min0), .max_v(max0),
        .empty(empty0), .err_timeout(err0)
    );

    list_fold_sink #(
        .WIDTH(WIDTH), .ACC_WIDTH(8), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT(WD_TIMEOUT)
    ) dut1 (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .start(start1), .done(done1),
        .lst(bus1), .sum(sum1), .count(count1), .min_v(min1), .max_v(max1),
        .empty(empty1), .err_timeout(err1)
    );

    logic                 cur_req, cur_done, cur_empty, cur_err;
    logic [15:0]          cur_sum;
    logic [CNT_WIDTH-1:0] cur_count;
    logic [WIDTH-1:0]     cur_min, cur_max;

    assign cur_req   = sel ? bus1.req : bus0.req;
    assign cur_done  = sel ? done1 : done0;
    assign cur_sum   = sel ? {8'h00, sum1} : sum0;
    assign cur_count = sel ? count1 : count0;
    assign cur_min   = sel ? min1 : min0;
    assign cur_max   = sel ? max1 : max0;
    assign cur_empty = sel ? empty1 : empty0;
    assign cur_err   = sel ? err1 : err0;

    int n_checks = 0;
    int n_errors = 0;
    int list_q[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: fold of list_q computed directly from the list contents
    task automatic check_results(input string tag);
        longint total;
        longint mask;
        int     mn, mx, n, acc_w;
        acc_w = sel ? 8 : 16;
        mask  = (longint'(1) << acc_w) - 1;
        total = 0;
        n     = list_q.size();
        mn    = 0;
        mx    = 0;
        foreach (list_q[i]) begin
            total += list_q[i];
            if (i == 0 || list_q[i] < mn) mn = list_q[i];
            if (i == 0 || list_q[i] > mx) mx = list_q[i];
        end
        check({tag, ".done"},  cur_done, 1);
        check({tag, ".sum"},   cur_sum, total & mask);
        check({tag, ".count"}, cur_count, (n > 255) ? 255 : n);
        check({tag, ".min"},   longint'($signed(cur_min)), mn);
        check({tag, ".max"},   longint'($signed(cur_max)), mx);
        check({tag, ".empty"}, cur_empty, (n == 0) ? 1 : 0);
        check({tag, ".err"},   cur_err, 0);
    endtask

    // Producer: serves list_q then eol, waiting 0..max_delay req-high cycles
    // before each answer. lat is the cycle (start edge = 0) where done shows.
    task automatic run_list(input int max_delay, input bit noise, input bit hold_start,
                            output int lat, output int sumw);
        int cyc, idx, w;
        bit finished;
        sumw     = 0;
        lat      = 0;
        idx      = 0;
        finished = 0;
        start_d  = 1'b1;
        @(posedge CLOCK_50); #1;
        start_d = hold_start;
        cyc     = 1;
        w       = $urandom_range(0, max_delay);
        sumw   += w;
        while (!finished && cyc < RUN_LIMIT) begin
            ack_d = 1'b0;
            eol_d = 1'b0;
            if (cur_done) begin
                finished = 1;
                lat      = cyc;
                start_d  = 1'b0;
            end else if (cur_req) begin
                if (w == 0) begin
                    ack_d = 1'b1;
                    if (idx < list_q.size()) begin
                        value_d = 8'(list_q[idx]);
                    end else begin
                        eol_d   = 1'b1;
                        value_d = 8'($urandom);
                    end
                    idx++;
                    if (idx <= list_q.size()) begin
                        w     = $urandom_range(0, max_delay);
                        sumw += w;
                    end
                end else begin
                    w--;
                end
            end else if (noise && $urandom_range(0, 1) == 1) begin
                ack_d   = 1'b1;
                eol_d   = 1'($urandom);
                value_d = 8'($urandom);
            end
            if (!finished) begin
                @(posedge CLOCK_50); #1;
                cyc++;
            end
        end
        ack_d   = 1'b0;
        eol_d   = 1'b0;
        start_d = 1'b0;
        check("run_bound", finished, 1);
    endtask

    initial begin
        int lat, sumw, cyc;

        // Reset state
        #5 RESET_N = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst.req0", bus0.req, 0);
        check("rst.done0", done0, 0);
        check("rst.sum0", sum0, 0);
        check("rst.count0", count0, 0);
        check("rst.min0", min0, 0);
        check("rst.max0", max0, 0);
        check("rst.empty0", empty0, 0);
        check("rst.err0", err0, 0);
        check("rst.req1", bus1.req, 0);
        check("rst.done1", done1, 0);
        RESET_N = 1'b1;
        @(posedge CLOCK_50); #1;

        // Reset in the middle of a run, after one element has been folded
        sel     = 1'b0;
        start_d = 1'b1;
        @(posedge CLOCK_50); #1;
        start_d = 1'b0;
        check("mid.req_rise", cur_req, 1);
        ack_d   = 1'b1;
        value_d = 8'd5;
        @(posedge CLOCK_50); #1;
        ack_d = 1'b0;
        check("mid.gap_req", cur_req, 0);
        @(posedge CLOCK_50); #1;
        check("mid.req", cur_req, 1);
        check("mid.sum", cur_sum, 5);
        RESET_N = 1'b0;
        #1;
        check("mid.rst_req", cur_req, 0);
        check("mid.rst_done", cur_done, 0);
        check("mid.rst_sum", cur_sum, 0);
        check("mid.rst_count", cur_count, 0);
        check("mid.rst_min", cur_min, 0);
        check("mid.rst_max", cur_max, 0);
        @(posedge CLOCK_50); #1;
        RESET_N = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("mid.idle_req", cur_req, 0);
        check("mid.idle_done", cur_done, 0);

        // Basic fold with zero-wait producer
        list_q = '{-2, -1, 0, 1, 2};
        run_list(0, 0, 0, lat, sumw);
        check_results("basic");
        check("basic.lat", lat, 12);

        // Empty list straight after a completed run
        list_q.delete();
        run_list(0, 0, 0, lat, sumw);
        check_results("empty");
        check("empty.lat", lat, 2);

        // Wrap and saturate, 16-bit accumulator
        list_q.delete();
        for (int i = 0; i < 300; i++) list_q.push_back(127);
        run_list(0, 0, 0, lat, sumw);
        check_results("wrap16");
        check("wrap16.sum_abs", cur_sum, 38100);
        check("wrap16.lat", lat, 602);

        // Same list through the 8-bit accumulator instance
        sel = 1'b1;
        #1;
        run_list(0, 0, 0, lat, sumw);
        check_results("wrap8");
        check("wrap8.sum_signed", longint'($signed(sum1)), -44);

        // Watchdog: producer never answers
        start_d = 1'b1;
        @(posedge CLOCK_50); #1;
        start_d = 1'b0;
        cyc     = 1;
        check("wd.req_rise", cur_req, 1);
        while (!cur_done && cyc < 200) begin
            @(posedge CLOCK_50); #1;
            cyc++;
        end
        check("wd.lat", cyc, 1 + WD_TIMEOUT + 1);
        check("wd.err", cur_err, 1);
        check("wd.empty", cur_empty, 0);
        check("wd.count", cur_count, 0);
        check("wd.sum", cur_sum, 0);
        repeat (3) begin
            @(posedge CLOCK_50); #1;
            check("wd.req_low", cur_req, 0);
        end

        // Randomized runs: delays 0..20, ack noise in GAP, start held high
        sel = 1'b0;
        #1;
        for (int r = 0; r < 20; r++) begin
            bit noise, hold;
            int n;
            list_q.delete();
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) list_q.push_back(int'($urandom_range(0, 255)) - 128);
            noise = 1'($urandom);
            hold  = 1'($urandom);
            run_list(20, noise, hold, lat, sumw);
            check_results("rand");
            check("rand.lat", lat, 2 * n + 2 + sumw);
            // ack pulses while DONE must not disturb the results
            for (int k = 0; k < 3; k++) begin
                ack_d   = 1'b1;
                eol_d   = 1'($urandom);
                value_d = 8'($urandom);
                @(posedge CLOCK_50); #1;
            end
            ack_d = 1'b0;
            eol_d = 1'b0;
            check_results("rand_hold");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/list_fold_sink.md
# list_fold_sink

Consumer stage for H2V list-producing function blocks. The block pulls elements one at a time over the list handshake (`req`/`ack`/`eol`/`value`) until end-of-list, folds them into a running signed sum, element count, minimum and maximum, and presents the results behind a start/done call interface. It sits directly downstream of a generated list producer such as `dfd_5` and replaces ad-hoc request toggling with a protocol-correct requester that includes a watchdog.

## Interface
- `WIDTH`, 8: element width; `value` is signed two's complement.
- `ACC_WIDTH`, 16: sum accumulator width; signed.
- `CNT_WIDTH`, 8: element counter width.
- `TIMEOUT`, 1023: maximum number of cycles `req` may wait for `ack` before the run aborts.
- `CLOCK_50`, in, 1: sole clock; all state is updated on the rising edge.
- `RESET_N`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: run request, sampled in IDLE or DONE.
- `done`, out, 1: results valid.
- `req`, out, 1: element request to the producer.
- `ack`, in, 1: producer strobe; `eol` and `value` are valid only while `ack` is high.
- `eol`, in, 1: end-of-list marker; `value` is ignored when this is high.
- `value`, in, WIDTH: list element.
- `sum`, out, ACC_WIDTH: wrapping sum of elements.
- `count`, out, CNT_WIDTH: number of elements, saturating.
- `min_v` / `max_v`, out, WIDTH: signed extremes of the elements.
- `empty`, out, 1: the list had zero elements.
- `err_timeout`, out, 1: the run was aborted by the watchdog.

## Operation
- States: IDLE, REQ, GAP, DONE.
- Reset values: state IDLE; `req`=0; `done`=0; `sum`=0; `count`=0; `min_v`=0; `max_v`=0; `empty`=0; `err_timeout`=0; watchdog=0.
- **IDLE**, `start`=1:
  - Clear `sum`, `count`, `err_timeout` and the watchdog.
  - Set `min_v` = most-positive value and `max_v` = most-negative value.
  - Go to REQ.
- **REQ**:
  - `req`=1 (registered output, high for the whole state).
  - `ack`=1, `eol`=0:
    - Add the sign-extended `value` to `sum`, wrapping modulo 2^ACC_WIDTH.
    - Increment `count`; it saturates at 2^CNT_WIDTH−1.
    - Update `min_v`/`max_v` with a signed compare.
    - Go to GAP.
  - `ack`=1, `eol`=1:
    - Go to DONE.
    - `empty` = (`count`==0).
    - If `empty`, force `min_v`=`max_v`=0.
  - `ack`=0: increment the watchdog. When it reaches TIMEOUT, set `err_timeout`=1, go to DONE and set `empty`=0.
- **GAP**:
  - `req`=0 for exactly one cycle.
  - Clear the watchdog.
  - Go to REQ.
  - `ack` seen in GAP is ignored; it is never counted twice.
- **DONE**:
  - `done`=1 and `req`=0.
  - Results hold stable.
  - `start`=1 clears `done` and begins a new run with the same actions as IDLE+`start`.
  - `start` is ignored while in REQ or GAP.
- `ack` while in IDLE or DONE is ignored.
- `RESET_N` low mid-run: everything returns to its reset value immediately, and `req` drops asynchronously.

## Timing
- `start` sampled at edge N → `req`=1 from N+1.
- `ack` sampled at edge M while in REQ → `req`=0 from M+1 (GAP) → `req`=1 from M+2.
- Element throughput: at best one element per 2 cycles.
- Terminating `ack` (with `eol`) at edge M → `done`=1 and final results valid from M+1.
- Total latency for an L-element list with zero-wait producer: 2L+2 cycles from `start` to `done`.
- Watchdog: with `ack` stuck low, `done`=1 and `err_timeout`=1 arrive exactly TIMEOUT+1 cycles after `req` rises.
- Simultaneous `ack`+`eol` on the first request: `done` arrives 2 cycles after `start`, with `empty`=1.

## Test plan
- **Reset:** assert `RESET_N`=0 mid-REQ → all outputs 0 on the same cycle; after release the block sits in IDLE with `req`=0.
- **Basic fold:** producer returns −2, −1, 0, 1, 2, then `eol`, with zero wait → `sum`=0, `count`=5, `min_v`=−2, `max_v`=2, `done` 12 cycles after `start`.
- **Empty list:** first ack carries `eol` → `empty`=1, `count`=0, `sum`=0, `min_v`=`max_v`=0, `done` at `start`+2.
- **Wrap and saturate:** 300 elements of value 127, `ACC_WIDTH`=16 → `count`=255, `sum`=38100; 300 elements of value 127 with `ACC_WIDTH`=8 → `sum`=(38100 mod 256) as signed = −44.
- **Watchdog:** producer never acks, `TIMEOUT`=15 → `err_timeout`=1 and `done`=1 exactly 16 cycles after `req` rises; `req`=0 from then on.
- **Protocol edges:**
  - Random ack delays of 0–20 cycles → results match the reference model.
  - `ack` pulsed during GAP or DONE is not counted.
  - `start` held high during a run does not restart the run.
  - `start` in DONE begins a fresh run with the results cleared.
